// File: rtl/gps_ca_signal_gen.sv
// GPS L1 C/A Gold-code generator tile with nav-data BPSK and strobes.
// Optional carrier I/Q NCO is built when CARRIER_EN is defined.
module gps_ca_signal_gen #(
  parameter int          CHIP_DIV       = 4,
  parameter int          CODE_LEN       = 1023,
  parameter int          EPOCHS_PER_BIT = 20,
  parameter logic [15:0] CARR_FCW       = 16'h2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DIV_W = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
  localparam int EP_W  = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CHIP_DIV - 1);
  localparam logic [9:0]       CHIP_MAX = 10'(CODE_LEN - 1);
  localparam logic [EP_W-1:0]  EP_MAX   = EP_W'(EPOCHS_PER_BIT - 1);

  logic [9:0]       g1_q, g1_d;
  logic [9:0]       g2_q, g2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       chip_cnt_q, chip_cnt_d;
  logic [EP_W-1:0]  epoch_q, epoch_d;
  logic             data_q, data_d;

  logic       adv;
  logic       restart;
  logic [3:0] tap_a;
  logic [3:0] tap_b;
  logic [3:0] idx_a;
  logic [3:0] idx_b;
  logic       chip;
  logic       mod;
  logic       g1_fb;
  logic       g2_fb;
  logic [1:0] iq;

  assign adv     = ena & ui_in[5];
  assign restart = ui_in[7];

  // Phase-selector taps, one-based stage numbers; PRN field 0 means PRN 32.
  always_comb begin
    tap_a = 4'd4;
    tap_b = 4'd9;
    unique case (ui_in[4:0])
      5'd1:  begin tap_a = 4'd2; tap_b = 4'd6;  end
      5'd2:  begin tap_a = 4'd3; tap_b = 4'd7;  end
      5'd3:  begin tap_a = 4'd4; tap_b = 4'd8;  end
      5'd4:  begin tap_a = 4'd5; tap_b = 4'd9;  end
      5'd5:  begin tap_a = 4'd1; tap_b = 4'd9;  end
      5'd6:  begin tap_a = 4'd2; tap_b = 4'd10; end
      5'd7:  begin tap_a = 4'd1; tap_b = 4'd8;  end
      5'd8:  begin tap_a = 4'd2; tap_b = 4'd9;  end
      5'd9:  begin tap_a = 4'd3; tap_b = 4'd10; end
      5'd10: begin tap_a = 4'd2; tap_b = 4'd3;  end
      5'd11: begin tap_a = 4'd3; tap_b = 4'd4;  end
      5'd12: begin tap_a = 4'd5; tap_b = 4'd6;  end
      5'd13: begin tap_a = 4'd6; tap_b = 4'd7;  end
      5'd14: begin tap_a = 4'd7; tap_b = 4'd8;  end
      5'd15: begin tap_a = 4'd8; tap_b = 4'd9;  end
      5'd16: begin tap_a = 4'd9; tap_b = 4'd10; end
      5'd17: begin tap_a = 4'd1; tap_b = 4'd4;  end
      5'd18: begin tap_a = 4'd2; tap_b = 4'd5;  end
      5'd19: begin tap_a = 4'd3; tap_b = 4'd6;  end
      5'd20: begin tap_a = 4'd4; tap_b = 4'd7;  end
      5'd21: begin tap_a = 4'd5; tap_b = 4'd8;  end
      5'd22: begin tap_a = 4'd6; tap_b = 4'd9;  end
      5'd23: begin tap_a = 4'd1; tap_b = 4'd3;  end
      5'd24: begin tap_a = 4'd4; tap_b = 4'd6;  end
      5'd25: begin tap_a = 4'd5; tap_b = 4'd7;  end
      5'd26: begin tap_a = 4'd6; tap_b = 4'd8;  end
      5'd27: begin tap_a = 4'd7; tap_b = 4'd9;  end
      5'd28: begin tap_a = 4'd8; tap_b = 4'd10; end
      5'd29: begin tap_a = 4'd1; tap_b = 4'd6;  end
      5'd30: begin tap_a = 4'd2; tap_b = 4'd7;  end
      5'd31: begin tap_a = 4'd3; tap_b = 4'd8;  end
      5'd0:  begin tap_a = 4'd4; tap_b = 4'd9;  end
    endcase
  end

  assign idx_a = tap_a - 4'd1;
  assign idx_b = tap_b - 4'd1;
  assign chip  = g1_q[9] ^ g2_q[idx_a] ^ g2_q[idx_b];
  assign mod   = chip ^ data_q;

  // Bit i holds stage i+1; stage 1 takes the feedback.
  assign g1_fb = g1_q[2] ^ g1_q[9];
  assign g2_fb = g2_q[1] ^ g2_q[2] ^ g2_q[5] ^
                 g2_q[7] ^ g2_q[8] ^ g2_q[9];

  always_comb begin
    g1_d       = g1_q;
    g2_d       = g2_q;
    div_d      = div_q;
    chip_cnt_d = chip_cnt_q;
    epoch_d    = epoch_q;
    data_d     = data_q;
    if (restart) begin
      g1_d       = 10'h3FF;
      g2_d       = 10'h3FF;
      div_d      = '0;
      chip_cnt_d = '0;
      epoch_d    = '0;
      data_d     = 1'b0;
    end else if (adv) begin
      if (div_q == DIV_MAX) begin
        div_d = '0;
        if (chip_cnt_q == CHIP_MAX) begin
          chip_cnt_d = '0;
          g1_d       = 10'h3FF;
          g2_d       = 10'h3FF;
          if (epoch_q == EP_MAX) begin
            epoch_d = '0;
            data_d  = ui_in[6];
          end else begin
            epoch_d = epoch_q + 1'b1;
          end
        end else begin
          chip_cnt_d = chip_cnt_q + 10'd1;
          g1_d       = {g1_q[8:0], g1_fb};
          g2_d       = {g2_q[8:0], g2_fb};
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1_q       <= 10'h3FF;
      g2_q       <= 10'h3FF;
      div_q      <= '0;
      chip_cnt_q <= '0;
      epoch_q    <= '0;
      data_q     <= 1'b0;
    end else begin
      g1_q       <= g1_d;
      g2_q       <= g2_d;
      div_q      <= div_d;
      chip_cnt_q <= chip_cnt_d;
      epoch_q    <= epoch_d;
      data_q     <= data_d;
    end
  end

`ifdef CARRIER_EN
  logic [15:0] nco_q, nco_d;

  always_comb begin
    nco_d = nco_q;
    if (restart) begin
      nco_d = '0;
    end else if (adv) begin
      nco_d = nco_q + CARR_FCW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nco_q <= '0;
    end else begin
      nco_q <= nco_d;
    end
  end

  assign iq = {nco_q[15] ^ nco_q[14] ^ mod, nco_q[15] ^ mod};

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in};
`else
  assign iq = 2'b00;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in, CARR_FCW};
`endif

  assign uo_out = {chip_cnt_q[9:8], iq, (div_q == DIV_MAX),
                   (chip_cnt_q == 10'd0), mod, chip};
  assign uio_out = chip_cnt_q[7:0];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_gps_ca_signal_gen.sv
// Directed bench for gps_ca_signal_gen: PRN codes, period, nav data,
// restart and enable behaviour.
module tb_gps_ca_signal_gen;

  localparam int EPB    = 4;
  localparam int EPOCH  = 1023 * 4;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors;
  int checks;

  gps_ca_signal_gen #(
    .CHIP_DIV(4),
    .CODE_LEN(1023),
    .EPOCHS_PER_BIT(EPB),
    .CARR_FCW(16'h2000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .ui_in(ui_in),
    .uo_out(uo_out),
    .uio_in(uio_in),
    .uio_out(uio_out),
    .uio_oe(uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart_prn(input logic [4:0] prn, input logic data);
    @(negedge clk);
    ui_in = {1'b1, data, 1'b1, prn};
    @(negedge clk);
    ui_in[7] = 1'b0;
  endtask

  task automatic get_chips(input int bitsel, output logic [9:0] v);
    for (int i = 0; i < 10; i++) begin
      v[9-i] = uo_out[bitsel];
      clks(4);
    end
  endtask

  logic [9:0] seq;

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'hA5;
    clks(3);
    rst = 1'b0;
    clks(1);

    chk("rst_chip", 32'(uo_out[0]), 32'd1);
    chk("rst_epoch", 32'(uo_out[2]), 32'd1);
    chk("rst_strobe", 32'(uo_out[3]), 32'd0);
    chk("rst_cnt_lo", 32'(uio_out), 32'd0);
    chk("rst_cnt_hi", 32'(uo_out[7:6]), 32'd0);
    chk("rst_oe", 32'(uio_oe), 32'hFF);
    chk("rst_mod", 32'(uo_out[1]), 32'd1);
`ifndef CARRIER_EN
    chk("rst_iq", 32'(uo_out[5:4]), 32'd0);
`endif

    restart_prn(5'd1, 1'b0);
    chk("strobe_c0_0", 32'(uo_out[3]), 32'd0);
    clks(3);
    chk("strobe_c0_3", 32'(uo_out[3]), 32'd1);
    clks(1);
    chk("strobe_c1_0", 32'(uo_out[3]), 32'd0);
    chk("cnt_after1", 32'(uio_out), 32'd1);
    clks(3);
    chk("strobe_c1_3", 32'(uo_out[3]), 32'd1);

    restart_prn(5'd1, 1'b0);
    get_chips(0, seq);
    chk("prn1", 32'(seq), 32'(10'o1440));
    restart_prn(5'd2, 1'b0);
    get_chips(0, seq);
    chk("prn2", 32'(seq), 32'(10'o1620));
    restart_prn(5'd5, 1'b0);
    get_chips(0, seq);
    chk("prn5", 32'(seq), 32'(10'o1133));
    restart_prn(5'd32 - 5'd0 - 5'd0 , 1'b0);
    get_chips(0, seq);
    chk("prn0_as32", 32'(seq), 32'(10'o1712));

    restart_prn(5'd1, 1'b0);
    clks(EPOCH - 1);
    chk("last_cnt_lo", 32'(uio_out), 32'hFE);
    chk("last_cnt_hi", 32'(uo_out[7:6]), 32'd3);
    chk("last_strobe", 32'(uo_out[3]), 32'd1);
    chk("last_epoch", 32'(uo_out[2]), 32'd0);
    clks(1);
    chk("wrap_epoch", 32'(uo_out[2]), 32'd1);
    chk("wrap_cnt_lo", 32'(uio_out), 32'd0);
    chk("wrap_cnt_hi", 32'(uo_out[7:6]), 32'd0);
    get_chips(0, seq);
    chk("prn1_repeat", 32'(seq), 32'(10'o1440));

    restart_prn(5'd1, 1'b0);
    clks(300 * 4);
    chk("mid_cnt_lo", 32'(uio_out), 32'h2C);
    chk("mid_cnt_hi", 32'(uo_out[7:6]), 32'd1);
    ui_in[7] = 1'b1;
    clks(1);
    chk("rs_cnt_lo", 32'(uio_out), 32'd0);
    chk("rs_cnt_hi", 32'(uo_out[7:6]), 32'd0);
    chk("rs_chip", 32'(uo_out[0]), 32'd1);
    chk("rs_epoch", 32'(uo_out[2]), 32'd1);
    clks(3);
    chk("rs_hold_cnt", 32'(uio_out), 32'd0);
    chk("rs_hold_strobe", 32'(uo_out[3]), 32'd0);
    ui_in[7] = 1'b0;

    restart_prn(5'd1, 1'b0);
    clks(4 * 4 + 2);
    chk("frz_pre_cnt", 32'(uio_out), 32'd4);
    chk("frz_pre_chip", 32'(uo_out[0]), 32'd1);
    ena = 1'b0;
    clks(50);
    chk("frz_cnt", 32'(uio_out), 32'd4);
    chk("frz_chip", 32'(uo_out[0]), 32'd1);
    chk("frz_strobe", 32'(uo_out[3]), 32'd0);
    ena = 1'b1;
    clks(1);
    chk("unfrz_strobe", 32'(uo_out[3]), 32'd1);
    clks(1);
    chk("unfrz_cnt", 32'(uio_out), 32'd5);
    chk("unfrz_chip", 32'(uo_out[0]), 32'd0);

    restart_prn(5'd1, 1'b1);
    chk("nav_e0", 32'(uo_out[1]), 32'd1);
    clks((EPB - 1) * EPOCH);
    chk("nav_elast_ep", 32'(uo_out[2]), 32'd1);
    chk("nav_elast", 32'(uo_out[1]), 32'd1);
    clks(EPOCH);
    chk("nav_wrap_ep", 32'(uo_out[2]), 32'd1);
    chk("nav_wrap_chip", 32'(uo_out[0]), 32'd1);
    chk("nav_wrap_mod", 32'(uo_out[1]), 32'd0);
    get_chips(1, seq);
    chk("nav_inv_seq", 32'(seq), 32'(10'b0011011111));

`ifdef CARRIER_EN
    restart_prn(5'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("nco_i", 32'(uo_out[4]), (i < 4) ? 32'd1 : 32'd0);
      clks(1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
